// File: rtl/fetch_pkg.sv
// Shared widths, instruction field positions and stack-operation encoding
// for the control-unit fetch/sequencing datapath.
package fetch_pkg;

   localparam int unsigned PC_W    = 9;
   localparam int unsigned IR_W    = 16;
   localparam int unsigned FLAGS_W = 4;

   localparam int unsigned OPC_HI  = 15;
   localparam int unsigned OPC_LO  = 11;
   localparam int unsigned ADDR_HI = 10;
   localparam int unsigned ADDR_LO = 2;

   localparam logic [OPC_HI-OPC_LO:0] OPC_RET = 5'b10101;

   typedef enum logic [1:0] {
      STK_IDLE,
      STK_PUSH,
      STK_POP,
      STK_REPLACE
   } stack_op_e;

endpackage

// File: rtl/fetch_sequencer_ret_stack.sv
// Return-context LIFO of {pc, flags} entries with full/empty status and a
// combinational top-of-stack read that reads as zero when empty.
module ret_stack
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned PC_BITS   = 9,
   parameter int unsigned FLAG_BITS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic                 pop,
   input  logic [PC_BITS-1:0]   wr_pc,
   input  logic [FLAG_BITS-1:0] wr_flags,
   output logic [PC_BITS-1:0]   top_pc,
   output logic [FLAG_BITS-1:0] top_flags,
   output logic                 full,
   output logic                 empty
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned SP_W  = IDX_W + 1;
   localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

   logic [SP_W-1:0]      sp;
   logic [PC_BITS-1:0]   mem_pc    [DEPTH];
   logic [FLAG_BITS-1:0] mem_flags [DEPTH];
   logic [IDX_W-1:0]     top_idx;
   logic [IDX_W-1:0]     wr_idx;
   stack_op_e            op;

   assign full    = (sp == SP_FULL);
   assign empty   = (sp == '0);
   assign top_idx = IDX_W'(sp - 1'b1);

   // Push+pop on a non-empty stack rewrites the top in place; on an empty
   // stack it degenerates to a plain push.
   always_comb begin
      op     = STK_IDLE;
      wr_idx = sp[IDX_W-1:0];
      unique case ({push, pop})
         2'b10: if (!full)  op = STK_PUSH;
         2'b01: if (!empty) op = STK_POP;
         2'b11: begin
            if (empty) begin
               op = STK_PUSH;
            end else begin
               op     = STK_REPLACE;
               wr_idx = top_idx;
            end
         end
         default: op = STK_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_pc[i]    <= '0;
            mem_flags[i] <= '0;
         end
      end else begin
         unique case (op)
            STK_PUSH: begin
               mem_pc[wr_idx]    <= wr_pc;
               mem_flags[wr_idx] <= wr_flags;
               sp                <= sp + 1'b1;
            end
            STK_REPLACE: begin
               mem_pc[wr_idx]    <= wr_pc;
               mem_flags[wr_idx] <= wr_flags;
            end
            STK_POP:  sp <= sp - 1'b1;
            default:  sp <= sp;
         endcase
      end
   end

   assign top_pc    = empty ? '0 : mem_pc[top_idx];
   assign top_flags = empty ? '0 : mem_flags[top_idx];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction register, program counter and subroutine return stack driven
// by the microcode sequencer's load/increment/push/pop strobes.
module fetch_sequencer #(
   parameter int unsigned STACK_DEPTH = 8,
   parameter int unsigned PC_W        = fetch_pkg::PC_W,
   parameter int unsigned IR_W        = fetch_pkg::IR_W,
   parameter int unsigned FLAGS_W     = fetch_pkg::FLAGS_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ir_load,
   input  logic [IR_W-1:0]    in_ir,
   input  logic               pc_load,
   input  logic               pc_inc,
   input  logic               pc_en_out,
   input  logic               push_en,
   input  logic               pop_en,
   input  logic [FLAGS_W-1:0] in_flags,
   output logic [IR_W-1:0]    out_ir,
   output logic [PC_W-1:0]    out_pc,
   output logic [PC_W-1:0]    pc_bus,
   output logic [PC_W-1:0]    stack_out_pc,
   output logic [FLAGS_W-1:0] stack_out_flags,
   output logic               stack_full,
   output logic               stack_empty
);

   import fetch_pkg::*;

   logic [IR_W-1:0] ir;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_src;
   logic            is_ret;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ir <= '0;
      else if (ir_load) ir <= in_ir;
   end

   // RET takes its target from the pre-pop top, so pop+load completes in one cycle.
   assign is_ret = (ir[OPC_HI:OPC_LO] == OPC_RET);
   assign pc_src = is_ret ? stack_out_pc : PC_W'(ir[ADDR_HI:ADDR_LO]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       pc <= '0;
      else if (pc_load) pc <= pc_src;
      else if (pc_inc)  pc <= pc + 1'b1;
   end

   ret_stack #(
      .DEPTH     (STACK_DEPTH),
      .PC_BITS   (PC_W),
      .FLAG_BITS (FLAGS_W)
   ) u_stack (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_en),
      .pop       (pop_en),
      .wr_pc     (pc),
      .wr_flags  (in_flags),
      .top_pc    (stack_out_pc),
      .top_flags (stack_out_flags),
      .full      (stack_full),
      .empty     (stack_empty)
   );

   assign out_ir = ir;
   assign out_pc = pc;
   assign pc_bus = pc_en_out ? pc : '0;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized checks of fetch_sequencer against a queue-based
// reference model of the IR, PC and return stack.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ir_load, pc_load, pc_inc, pc_en_out, push_en, pop_en;
   logic [15:0] in_ir;
   logic [3:0]  in_flags;
   logic [15:0] out_ir;
   logic [8:0]  out_pc, pc_bus, stack_out_pc;
   logic [3:0]  stack_out_flags;
   logic        stack_full, stack_empty;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [15:0] m_ir;
   logic [8:0]  m_pc;
   logic [12:0] m_stk[$];

   always #5 clk = ~clk;

   fetch_sequencer #(.STACK_DEPTH(8)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ir_load         (ir_load),
      .in_ir           (in_ir),
      .pc_load         (pc_load),
      .pc_inc          (pc_inc),
      .pc_en_out       (pc_en_out),
      .push_en         (push_en),
      .pop_en          (pop_en),
      .in_flags        (in_flags),
      .out_ir          (out_ir),
      .out_pc          (out_pc),
      .pc_bus          (pc_bus),
      .stack_out_pc    (stack_out_pc),
      .stack_out_flags (stack_out_flags),
      .stack_full      (stack_full),
      .stack_empty     (stack_empty)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [12:0] m_top();
      return (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 13'd0;
   endfunction

   task automatic model_reset();
      m_ir = '0;
      m_pc = '0;
      m_stk.delete();
   endtask

   task automatic check_all(input string tag);
      logic [12:0] t;
      t = m_top();
      check_eq({tag, ".ir"},    32'(out_ir), 32'(m_ir));
      check_eq({tag, ".pc"},    32'(out_pc), 32'(m_pc));
      check_eq({tag, ".bus"},   32'(pc_bus), pc_en_out ? 32'(m_pc) : 32'd0);
      check_eq({tag, ".tpc"},   32'(stack_out_pc), 32'(t[12:4]));
      check_eq({tag, ".tfl"},   32'(stack_out_flags), 32'(t[3:0]));
      check_eq({tag, ".full"},  32'(stack_full), 32'(m_stk.size() == 8));
      check_eq({tag, ".empty"}, 32'(stack_empty), 32'(m_stk.size() == 0));
   endtask

   // Apply one clock with the currently driven inputs, advance the model, compare.
   task automatic step(input string tag);
      logic [8:0]  n_pc, src;
      logic [12:0] t;
      int          n;
      t   = m_top();
      n   = m_stk.size();
      src = (m_ir[15:11] == 5'b10101) ? t[12:4] : m_ir[10:2];
      n_pc = pc_load ? src : (pc_inc ? m_pc + 9'd1 : m_pc);
      if (push_en && pop_en && n > 0)  m_stk[n-1] = {m_pc, in_flags};
      else if (push_en && n < 8)       m_stk.push_back({m_pc, in_flags});
      else if (pop_en && !push_en && n > 0) void'(m_stk.pop_back());
      if (ir_load) m_ir = in_ir;
      m_pc = n_pc;
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic idle();
      ir_load = 0; pc_load = 0; pc_inc = 0; pc_en_out = 0;
      push_en = 0; pop_en = 0; in_ir = '0; in_flags = '0;
   endtask

   task automatic set_pc(input logic [8:0] v);
      idle();
      ir_load = 1; in_ir = {5'b00000, v, 2'b00};
      step("setpc_ir");
      idle();
      pc_load = 1; pc_en_out = 1;
      step("setpc_ld");
      idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout reached");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      rst_n = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst_n = 1;

      // get some non-zero state, then reset asynchronously mid-cycle
      set_pc(9'd77);
      in_flags = 4'hC; push_en = 1;
      step("pre_rst_push");
      idle();
      ir_load = 1; in_ir = 16'h1234;
      #2 rst_n = 0;
      #1;
      model_reset();
      check_all("async_rst");
      check_eq("async_rst.empty1", 32'(stack_empty), 32'd1);
      @(posedge clk); #1;
      check_all("rst_held");
      rst_n = 1;
      ir_load = 1; in_ir = 16'hA5C3;
      step("ir_after_rst");
      check_eq("ir_a5c3", 32'(out_ir), 32'hA5C3);
      idle();

      // PC counting through wrap
      ir_load = 1; in_ir = 16'h0000;
      step("ir_clear");
      idle();
      pc_inc = 1;
      for (int i = 1; i <= 512; i++) begin
         pc_en_out = i[0];
         step("pc_inc");
         check_eq("pc_count", 32'(out_pc), 32'(i % 512));
      end
      idle();
      ir_load = 1; in_ir = {5'b00000, 9'd37, 2'b00};
      step("ir37");
      idle();
      pc_load = 1; pc_inc = 1;
      step("load_wins");
      check_eq("load_wins_pc", 32'(out_pc), 32'd37);
      check_eq("bus_off", 32'(pc_bus), 32'd0);
      idle();

      // call / return
      set_pc(9'd100);
      ir_load = 1; in_ir = {5'b00000, 9'd200, 2'b00};
      step("ir200");
      idle();
      in_flags = 4'b1010; push_en = 1; pc_load = 1;
      step("call");
      check_eq("call_pc", 32'(out_pc), 32'd200);
      check_eq("call_tpc", 32'(stack_out_pc), 32'd100);
      check_eq("call_tfl", 32'(stack_out_flags), 32'b1010);
      idle();
      ir_load = 1; in_ir = {5'b10101, 11'd0};
      step("ir_ret");
      idle();
      pop_en = 1; pc_load = 1;
      step("ret");
      check_eq("ret_pc", 32'(out_pc), 32'd100);
      check_eq("ret_empty", 32'(stack_empty), 32'd1);
      idle();

      // nesting to full, overflow push, unwind
      for (int i = 1; i <= 9; i++) begin
         set_pc(9'(i));
         push_en = 1; in_flags = 4'(i);
         step("nest_push");
         idle();
      end
      check_eq("nest_full", 32'(stack_full), 32'd1);
      check_eq("nest_top", 32'(stack_out_pc), 32'd8);
      for (int i = 8; i >= 1; i--) begin
         check_eq("unwind_top", 32'(stack_out_pc), 32'(i));
         pop_en = 1;
         step("unwind_pop");
         idle();
      end
      check_eq("unwind_empty", 32'(stack_empty), 32'd1);
      pop_en = 1;
      step("empty_pop");
      check_eq("empty_pop_tpc", 32'(stack_out_pc), 32'd0);
      check_eq("empty_pop_empty", 32'(stack_empty), 32'd1);
      idle();

      // simultaneous push and pop replaces top
      set_pc(9'd50);
      push_en = 1; in_flags = 4'h3;
      step("pp_push");
      idle();
      set_pc(9'd60);
      push_en = 1; pop_en = 1; in_flags = 4'h7;
      step("pp_both");
      check_eq("pp_tpc", 32'(stack_out_pc), 32'd60);
      check_eq("pp_tfl", 32'(stack_out_flags), 32'h7);
      idle();
      pop_en = 1;
      step("pp_pop");
      check_eq("pp_depth1", 32'(stack_empty), 32'd1);
      idle();

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         ir_load   = ($urandom_range(3) == 0);
         in_ir     = 16'($urandom);
         if ($urandom_range(3) == 0) in_ir[15:11] = 5'b10101;
         pc_load   = ($urandom_range(3) == 0);
         pc_inc    = ($urandom_range(1) == 0);
         pc_en_out = ($urandom_range(1) == 0);
         push_en   = ($urandom_range(2) == 0);
         pop_en    = ($urandom_range(2) == 0);
         in_flags  = 4'($urandom);
         step("rand");
      end
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control-unit fetch/sequencing datapath combining three functions: the 16-bit instruction register, the 9-bit program counter and the PC/flags subroutine stack.
- The microcode sequencer drives the load, increment, push and pop strobes.
- The block supplies the current instruction, the PC and the stacked return context to the rest of the control unit.

Parameters:
- STACK_DEPTH, 8, number of stack entries (power of two, at least 2).
- PC_W, 9, program counter width.
- IR_W, 16, instruction width.
- FLAGS_W, 4, flags width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ir_load  in  1  capture in_ir into the IR.
- in_ir  in  16  instruction word from program memory.
- pc_load  in  1  load the PC from the selected source.
- pc_inc  in  1  increment the PC.
- pc_en_out  in  1  drive the PC onto pc_bus.
- push_en  in  1  push {PC, in_flags} onto the stack.
- pop_en  in  1  pop the stack.
- in_flags  in  4  current ALU flags to save on push.
- out_ir  out  16  IR contents.
- out_pc  out  9  PC contents (always valid).
- pc_bus  out  9  PC when pc_en_out=1, else 0.
- stack_out_pc  out  9  top-of-stack PC field.
- stack_out_flags  out  4  top-of-stack flags field.
- stack_full  out  1  pointer equals STACK_DEPTH.
- stack_empty  out  1  pointer equals 0.

Behaviour:
- Reset (async, rst_n=0): IR=0, PC=0, stack pointer=0, all stack entries=0, so all outputs are 0 and stack_empty=1. Reset asserted mid-operation aborts the operation immediately.
- IR: when ir_load=1 at a rising edge, IR<=in_ir; otherwise IR holds. out_ir is the register output with no combinational bypass.
- PC source mux is combinational:
  - If IR[15:11]==5'b10101 (RET), the source is stack_out_pc.
  - Otherwise the source is IR[10:2].
- PC update priority: pc_load over pc_inc. pc_load=1 gives PC<=source. Else pc_inc=1 gives PC<=PC+1 modulo 512 (511 wraps to 0). Else PC holds.
- pc_en_out affects only pc_bus and never changes state.
- Stack is a LIFO of {pc[8:0], flags[3:0]} entries with pointer sp, range 0..STACK_DEPTH.
  - stack_out_* is a combinational read of entry sp-1. When empty, stack_out_* = 0.
- Push only (not full): entry[sp]<={PC, in_flags}, sp<=sp+1.
  - The stored PC is the pre-edge register value. This holds even if pc_load or pc_inc fires in the same cycle, which is how CALL saves the return address and jumps in one cycle.
- Pop only (not empty): sp<=sp-1.
  - A pc_load in the same cycle with RET in the IR uses the pre-pop top, so RET completes in one cycle.
- Push and pop in the same cycle, not empty: entry[sp-1] is overwritten with the new value and sp is unchanged. If empty, the pair acts as a push.
- Push when full: ignored, with no state change.
- Pop when empty: ignored, and the outputs stay 0.
- Flags restore is the consumer's job. stack_out_flags is valid in the pop cycle, before the edge.
- All outputs are glitch-free register outputs except pc_bus and stack_out_*, which are combinational from registers only.

Decomposition:
- Shared package fetch_pkg holds:
  - width constants PC_W, IR_W, FLAGS_W;
  - opcode field slice positions (15:11) and the immediate-address slice (10:2);
  - the RET opcode constant 5'b10101.
- One sub-module is natural: ret_stack, a parameterised LIFO holding PC and flags with full/empty outputs.
- The IR and PC are small enough to stay inline in fetch_sequencer.

Test Plan:
- Reset: pulse rst_n low mid-cycle with ir_load=1 → all outputs 0 asynchronously, stack_empty=1. After release, ir_load with in_ir=16'hA5C3 → out_ir=16'hA5C3 on the next edge.
- PC counting: pc_inc held for 512 cycles from 0 → out_pc goes 1,2,…,511,0. pc_load and pc_inc together with IR[10:2]=9'd37 → PC=37 (load wins). pc_en_out=0 → pc_bus=0.
- Call/return:
  - PC=100, in_flags=4'b1010, IR[10:2]=200, push_en and pc_load together → PC=200, stack_out_pc=100, stack_out_flags=1010.
  - Then IR=5'b10101 opcode, pop_en and pc_load together → PC=100, stack_empty=1.
- Nesting and full: push PCs 1..8 → stack_full=1, top=8. Ninth push of 9 → ignored, top=8. Eight pops → tops 8..1 in order, then empty.
- Empty pop: pop_en on an empty stack → sp stays 0, stack_out_pc=0, stack_empty=1.
- Simultaneous push and pop with top {50, 4'h3}, PC=60, flags 4'h7 → top becomes {60, 7} and depth is unchanged.
